// File: rtl/debug_mem_dumper.sv
// debug_mem_dumper
// Debug-unit sequencer that walks the whole data memory while the pipeline
// is halted and streams every word MSB-first, one byte at a time, through the
// UART TX start/done handshake. While busy it raises the debug override so the
// MEM-stage access select hands the read port to this block.
//
// Optional feature macro: DEBUG_DUMP_CHECKSUM_EN
//   When defined, one extra byte (XOR of every transmitted data byte) is sent
//   after the last word, before the completion pulse.
module debug_mem_dumper #(
  parameter int REG_SIZE  = 5,
  parameter int DATA_SIZE = 32,
  parameter int MEM_DEPTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic [DATA_SIZE-1:0] i_mem_data,
  input  logic                 i_tx_done,
  output logic                 o_debug_unit_flag,
  output logic                 o_mem_read_enable,
  output logic [REG_SIZE-1:0]  o_mem_read_addr,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int NBYTES = DATA_SIZE / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [REG_SIZE-1:0] LAST_ADDR = REG_SIZE'(MEM_DEPTH - 1);
  localparam logic [IDXW-1:0]     TOP_IDX   = IDXW'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPTURE,
    SEND,
    WAIT_TX,
    NEXT,
    FINISH
`ifdef DEBUG_DUMP_CHECKSUM_EN
    ,
    CHKSUM
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [REG_SIZE-1:0]   addr_q, addr_d;
  logic [DATA_SIZE-1:0]  word_q, word_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [7:0]            cur_byte;
  logic [7:0]            tx_byte;

`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [7:0]            acc_q, acc_d;
  logic                  chk_q, chk_d;
`endif

  // Byte of the captured word selected by the down-counting byte index,
  // so index NBYTES-1 (the most significant byte) goes out first.
  always_comb begin
    cur_byte = word_q[{idx_q, 3'b000} +: 8];
  end

`ifdef DEBUG_DUMP_CHECKSUM_EN
  // While the checksum byte is being sent the accumulator replaces the word byte.
  always_comb begin
    tx_byte = chk_q ? acc_q : cur_byte;
  end
`else
  // Without the checksum feature the transmitted byte is always a word byte.
  always_comb begin
    tx_byte = cur_byte;
  end
`endif

  // Sequencer next-state logic; all outputs are decoded from the current state
  // so an asynchronous reset drives every output low immediately.
  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    word_d            = word_q;
    idx_d             = idx_q;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    acc_d             = acc_q;
    chk_d             = chk_q;
`endif
    o_mem_read_enable = 1'b0;
    o_mem_read_addr   = '0;
    o_tx_start        = 1'b0;
    o_tx_data         = 8'h00;
    o_done            = 1'b0;
    o_busy            = (state_q != IDLE);
    o_debug_unit_flag = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = REQ;
          addr_d  = '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
          acc_d   = 8'h00;
          chk_d   = 1'b0;
`endif
        end
      end

      REQ: begin
        o_mem_read_enable = 1'b1;
        o_mem_read_addr   = addr_q;
        state_d           = CAPTURE;
      end

      CAPTURE: begin
        word_d  = i_mem_data;
        idx_d   = TOP_IDX;
        state_d = SEND;
      end

      SEND: begin
        o_tx_start = 1'b1;
        o_tx_data  = tx_byte;
`ifdef DEBUG_DUMP_CHECKSUM_EN
        if (!chk_q) begin
          acc_d = acc_q ^ cur_byte;
        end
`endif
        state_d = WAIT_TX;
      end

      WAIT_TX: begin
        o_tx_data = tx_byte;
        if (i_tx_done) begin
          if (idx_q != '0) begin
            idx_d   = idx_q - IDXW'(1);
            state_d = SEND;
          end else begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
            state_d = chk_q ? FINISH : NEXT;
`else
            state_d = NEXT;
`endif
          end
        end
      end

      NEXT: begin
        if (addr_q == LAST_ADDR) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
          state_d = CHKSUM;
`else
          state_d = FINISH;
`endif
        end else begin
          addr_d  = addr_q + REG_SIZE'(1);
          state_d = REQ;
        end
      end

`ifdef DEBUG_DUMP_CHECKSUM_EN
      CHKSUM: begin
        chk_d   = 1'b1;
        idx_d   = '0;
        state_d = SEND;
      end
`endif

      FINISH: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, address counter, word register and byte index registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

`ifdef DEBUG_DUMP_CHECKSUM_EN
  // Running XOR of sent data bytes and the flag marking the checksum byte.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_q <= 8'h00;
      chk_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      chk_q <= chk_d;
    end
  end
`endif

endmodule

// File: tb/tb_debug_mem_dumper.sv
// tb_debug_mem_dumper
// Drives whole-memory dumps through debug_mem_dumper with a behavioural memory
// and UART TX responder, then compares the captured byte stream, address walk
// and handshake timing against a reference built from the dump rules.
`timescale 1ns/1ps
module tb_debug_mem_dumper;

  localparam int REG_SIZE  = 5;
  localparam int DATA_SIZE = 32;
  localparam int MEM_DEPTH = 32;
  localparam int NB        = DATA_SIZE / 8;

  logic                 clock      = 1'b0;
  logic                 resetN     = 1'b0;
  logic                 startDrv   = 1'b0;
  logic                 startNoise = 1'b0;
  logic                 iStart;
  logic [DATA_SIZE-1:0] memData    = '0;
  logic                 txDone     = 1'b0;

  logic                 oDebugFlag;
  logic                 oMemReadEnable;
  logic [REG_SIZE-1:0]  oMemReadAddr;
  logic                 oTxStart;
  logic [7:0]           oTxData;
  logic                 oBusy;
  logic                 oDone;

  assign iStart = startDrv | startNoise;

  debug_mem_dumper #(
    .REG_SIZE (REG_SIZE),
    .DATA_SIZE(DATA_SIZE),
    .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .i_clk            (clock),
    .i_reset_n        (resetN),
    .i_start          (iStart),
    .i_mem_data       (memData),
    .i_tx_done        (txDone),
    .o_debug_unit_flag(oDebugFlag),
    .o_mem_read_enable(oMemReadEnable),
    .o_mem_read_addr  (oMemReadAddr),
    .o_tx_start       (oTxStart),
    .o_tx_data        (oTxData),
    .o_busy           (oBusy),
    .o_done           (oDone)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];
  int txDelay   = 0;
  bit spurMode  = 1'b0;
  bit noiseMode = 1'b0;

  // Count rising edges so events seen at the falling edge carry a cycle stamp.
  int cyc = 0;
  always @(posedge clock) cyc++;

  // Memory model: data for a strobed address shows up in the following
  // cycle; any other cycle carries garbage so a mistimed capture is visible.
  logic                prevReadEn = 1'b0;
  logic [REG_SIZE-1:0] prevAddr   = '0;
  always @(negedge clock) begin
    if (prevReadEn) memData = mem[prevAddr];
    else            memData = $urandom;
    prevReadEn = oMemReadEnable;
    prevAddr   = oMemReadAddr;
  end

  // UART TX responder: one-cycle done pulse a configurable number of cycles
  // after each start, optional spurious done pulses outside WAIT_TX, and
  // optional random start pulses while a dump is in progress.
  bit   pending  = 1'b0;
  bit   spurHold = 1'b0;
  int   cnt      = 0;
  logic doneNext;
  always @(negedge clock) begin
    doneNext = 1'b0;
    if (spurHold) begin
      doneNext = 1'b1;
      spurHold = 1'b0;
    end
    if (pending) begin
      if (cnt == 0) begin
        doneNext = 1'b1;
        pending  = 1'b0;
        if (spurMode) spurHold = 1'b1;
      end else begin
        cnt--;
      end
    end
    if (oTxStart) begin
      pending = 1'b1;
      cnt     = (txDelay < 0) ? int'($urandom_range(0, 3)) : txDelay;
      if (spurMode) doneNext = 1'b1;
    end
    txDone     = doneNext;
    startNoise = noiseMode && oBusy && ($urandom_range(0, 3) == 0);
  end

  // Monitor: record every launched byte, every read address, done pulses,
  // and whether the byte is still held in the cycle after its start pulse.
  byte unsigned gotBytes[$];
  int           gotByteCyc[$];
  int           gotAddrs[$];
  int           gotAddrCyc[$];
  int           doneCnt   = 0;
  int           holdErrs  = 0;
  bit           holdArmed = 1'b0;
  logic [7:0]   holdByte  = 8'h00;
  always @(negedge clock) begin
    if (holdArmed && (oTxData !== holdByte)) holdErrs++;
    holdArmed = 1'b0;
    if (oTxStart) begin
      gotBytes.push_back(oTxData);
      gotByteCyc.push_back(cyc);
      holdArmed = 1'b1;
      holdByte  = oTxData;
    end
    if (oMemReadEnable) begin
      gotAddrs.push_back(int'(oMemReadAddr));
      gotAddrCyc.push_back(cyc);
    end
    if (oDone) doneCnt++;
  end

  typedef struct {
    int         memKind;
    int         txDelay;
    bit         spur;
    bit         noise;
    bit         checkEnds;
    logic [7:0] expFirst;
    logic [7:0] expByte127;
    bit         checkChk;
    logic [7:0] expChk;
  } row_t;

  row_t rows[6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One complete dump for a table row, compared against the reference stream.
  task automatic applyStimulus(input int id, input row_t r);
    byte unsigned         expBytes[$];
    logic [DATA_SIZE-1:0] w;
    logic [7:0]           b;
    logic [7:0]           chk;
    int byteBase, addrBase, doneBase, holdBase, startCyc;
    int nGot, nCmp, mism, firstBad, gapExp;

    for (int k = 0; k < MEM_DEPTH; k++) begin
      case (r.memKind)
        0:       mem[k] = DATA_SIZE'(32'hA0B0C0D0 + k);
        1:       mem[k] = $urandom;
        2:       mem[k] = 32'h01020304;
        default: mem[k] = (k == 0) ? 32'h000000FF : 32'h0;
      endcase
    end
    txDelay   = r.txDelay;
    spurMode  = r.spur;
    noiseMode = r.noise;

    chk = 8'h00;
    for (int k = 0; k < MEM_DEPTH; k++) begin
      w = mem[k];
      for (int j = 0; j < NB; j++) begin
        b = w[DATA_SIZE-1-8*j -: 8];
        expBytes.push_back(b);
        chk ^= b;
      end
    end
`ifdef DEBUG_DUMP_CHECKSUM_EN
    expBytes.push_back(chk);
`endif

    @(negedge clock);
    byteBase = gotBytes.size();
    addrBase = gotAddrs.size();
    doneBase = doneCnt;
    holdBase = holdErrs;
    startDrv = 1'b1;
    startCyc = cyc + 1;
    @(negedge clock);
    startDrv = 1'b0;

    for (int t = 0; t < 8000 && doneCnt == doneBase; t++) @(negedge clock);
    checkOutput($sformatf("r%0d.doneSeen", id), doneCnt > doneBase, 1);
    noiseMode = 1'b0;
    repeat (2) @(negedge clock);
    spurMode = 1'b0;

    checkOutput($sformatf("r%0d.busyAfterDone", id), {oBusy, oDebugFlag}, 2'b00);
    checkOutput($sformatf("r%0d.donePulses", id), doneCnt - doneBase, 1);

    nGot = gotBytes.size() - byteBase;
    checkOutput($sformatf("r%0d.byteCount", id), nGot, expBytes.size());
    nCmp = (nGot < expBytes.size()) ? nGot : expBytes.size();
    mism = 0;
    firstBad = -1;
    for (int i = 0; i < nCmp; i++) begin
      if (gotBytes[byteBase+i] != expBytes[i]) begin
        if (firstBad < 0) firstBad = i;
        mism++;
      end
    end
    checkOutput($sformatf("r%0d.byteStream(firstBad=%0d)", id, firstBad), mism, 0);
    checkOutput($sformatf("r%0d.txDataHold", id), holdErrs - holdBase, 0);

    checkOutput($sformatf("r%0d.addrCount", id), gotAddrs.size() - addrBase, MEM_DEPTH);
    mism = 0;
    for (int k = 0; k < MEM_DEPTH && addrBase + k < gotAddrs.size(); k++) begin
      if (gotAddrs[addrBase+k] != k) mism++;
    end
    checkOutput($sformatf("r%0d.addrOrder", id), mism, 0);

    if (nGot > 0 && gotAddrs.size() > addrBase) begin
      checkOutput($sformatf("r%0d.readLatency", id), gotAddrCyc[addrBase] - startCyc, 0);
      checkOutput($sformatf("r%0d.firstTxLatency", id), gotByteCyc[byteBase] - startCyc, 2);
    end else begin
      checkOutput($sformatf("r%0d.nothingSent", id), nGot, expBytes.size());
    end

    // Start-to-start spacing with a fixed responder delay d: 2+d inside a word,
    // 5+d into a new word (NEXT, REQ, CAPTURE), 4+d into the checksum byte.
    if (r.txDelay >= 0) begin
      mism = 0;
      for (int i = 1; i < nCmp; i++) begin
        if (i == MEM_DEPTH * NB) gapExp = 4 + r.txDelay;
        else if (i % NB == 0)    gapExp = 5 + r.txDelay;
        else                     gapExp = 2 + r.txDelay;
        if (gotByteCyc[byteBase+i] - gotByteCyc[byteBase+i-1] != gapExp) mism++;
      end
      checkOutput($sformatf("r%0d.byteSpacing", id), mism, 0);
    end

    if (r.checkEnds && nGot >= MEM_DEPTH * NB) begin
      checkOutput($sformatf("r%0d.firstByte", id), gotBytes[byteBase], r.expFirst);
      checkOutput($sformatf("r%0d.lastDataByte", id), gotBytes[byteBase+MEM_DEPTH*NB-1], r.expByte127);
    end
`ifdef DEBUG_DUMP_CHECKSUM_EN
    if (r.checkChk && nGot >= MEM_DEPTH * NB + 1) begin
      checkOutput($sformatf("r%0d.checksumByte", id), gotBytes[byteBase+MEM_DEPTH*NB], r.expChk);
    end
`endif
  endtask

  initial begin
    int b0, d0;

    rows[0] = '{0,  5, 1'b0, 1'b0, 1'b1, 8'hA0, 8'hEF, 1'b0, 8'h00};
    rows[1] = '{1,  0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    rows[2] = '{1, -1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    rows[3] = '{2,  0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h04, 1'b1, 8'h00};
    rows[4] = '{3,  1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 8'hFF};
    rows[5] = '{0,  0, 1'b1, 1'b1, 1'b1, 8'hA0, 8'hEF, 1'b0, 8'h00};

    for (int k = 0; k < MEM_DEPTH; k++) mem[k] = DATA_SIZE'(32'hA0B0C0D0 + k);
    txDelay = 2;

    // Reset held with a pending start request: everything stays quiet.
    resetN   = 1'b0;
    startDrv = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("resetOutputsZero",
                {oDebugFlag, oMemReadEnable, oMemReadAddr, oTxStart, oTxData, oBusy, oDone}, 0);

    // Release: the held start is taken on the very next edge.
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    checkOutput("startAfterRelease", {oMemReadEnable, oMemReadAddr}, {1'b1, REG_SIZE'(0)});
    startDrv = 1'b0;

    // Abort that dump with reset part-way through address 7.
    b0 = gotBytes.size() - 1;
    if (b0 < 0) b0 = 0;
    b0 = 0;
    for (int t = 0; t < 4000 && gotBytes.size() < 30; t++) @(negedge clock);
    checkOutput("abortReached", gotBytes.size() >= 30, 1);
    d0 = doneCnt;
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("midResetOutputsZero",
                {oDebugFlag, oMemReadEnable, oMemReadAddr, oTxStart, oTxData, oBusy, oDone}, 0);
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("noDoneAfterAbort", doneCnt - d0, 0);
    checkOutput("idleAfterAbort", {oBusy, oTxStart, oMemReadEnable}, 3'b000);

    // Table-driven full dumps; the first one also shows a restart from address 0.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i, rows[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
